// File: rtl/writeback_register_file.sv
// MIPS-style write-back stage merged with the 32x32 register file.
// Selects the write-back value, writes it on the rising edge and bypasses it to both read ports.
module writeback_register_file #(
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_input,
    input  logic        MemToReg_input,
    input  logic        Jal_input,
    input  logic [4:0]  WriteRegister_input,
    input  logic [31:0] ReadData_input,
    input  logic [31:0] ALUResult_input,
    input  logic [31:0] LinkAddress_input,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [31:0] ReadData1_output,
    output logic [31:0] ReadData2_output,
    output logic [31:0] WriteBackData_output,
    output logic        WriteEnable_output
);

    localparam logic [4:0] LINK_REG = 5'd31;
    localparam logic [4:0] GP_REG   = 5'd28;
    localparam logic [4:0] SP_REG   = 5'd29;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [31:0] write_data;
    logic [4:0]  write_dest;
    logic        write_en;

    always_comb begin
        write_data = ALUResult_input;
        if (Jal_input) begin
            write_data = LinkAddress_input;
        end else if (MemToReg_input) begin
            write_data = ReadData_input;
        end
    end

    // jal always links into $ra, whatever destination MEM/WB carries
    always_comb begin
        write_dest = Jal_input ? LINK_REG : WriteRegister_input;
        write_en   = (RegWrite_input || Jal_input) && (write_dest != 5'd0) && !reset;
    end

    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'd0;
            end
            regs_d[GP_REG] = GP_INIT;
            regs_d[SP_REG] = SP_INIT;
        end else if (write_en) begin
            regs_d[write_dest] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Write-first: a read of the register being written sees the new value this cycle
    always_comb begin
        ReadData1_output = regs_q[ReadRegister1];
        ReadData2_output = regs_q[ReadRegister2];
        if (write_en && (ReadRegister1 == write_dest)) begin
            ReadData1_output = write_data;
        end
        if (write_en && (ReadRegister2 == write_dest)) begin
            ReadData2_output = write_data;
        end
        if (ReadRegister1 == 5'd0) begin
            ReadData1_output = 32'd0;
        end
        if (ReadRegister2 == 5'd0) begin
            ReadData2_output = 32'd0;
        end
    end

    assign WriteBackData_output = write_data;
    assign WriteEnable_output   = write_en;

endmodule

// File: tb/tb_writeback_register_file.sv
// Scoreboard bench for writeback_register_file: directed corner cases followed by random traffic,
// checked against an array model of the architectural register state.
module tb_writeback_register_file;

    localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT = 32'h1000_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic        mem_to_reg;
    logic        jal;
    logic [4:0]  write_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] link_addr;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wb_data;
    logic        wb_en;

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wb;
        logic        we;
    } expect_t;

    expect_t     exp_q[$];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    writeback_register_file #(
        .SP_INIT(SP_INIT),
        .GP_INIT(GP_INIT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .RegWrite_input      (reg_write),
        .MemToReg_input      (mem_to_reg),
        .Jal_input           (jal),
        .WriteRegister_input (write_reg),
        .ReadData_input      (read_data),
        .ALUResult_input     (alu_result),
        .LinkAddress_input   (link_addr),
        .ReadRegister1       (read_reg1),
        .ReadRegister2       (read_reg2),
        .ReadData1_output    (rd1),
        .ReadData2_output    (rd2),
        .WriteBackData_output(wb_data),
        .WriteEnable_output  (wb_en)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[28] = GP_INIT;
        model[29] = SP_INIT;
    endtask

    // Drive one cycle of inputs, predict the outputs from the architectural model,
    // then commit the cycle's effect to the model at the clock edge.
    task automatic apply_stimulus(input string tag, input logic rst, input logic rw, input logic m2r,
                                  input logic j, input logic [4:0] wr, input logic [31:0] rdata,
                                  input logic [31:0] alu, input logic [31:0] link,
                                  input logic [4:0] r1, input logic [4:0] r2);
        expect_t     e;
        logic [4:0]  dest;
        reset = rst; reg_write = rw; mem_to_reg = m2r; jal = j; write_reg = wr;
        read_data = rdata; alu_result = alu; link_addr = link; read_reg1 = r1; read_reg2 = r2;
        e.tag = tag;
        e.wb  = j ? link : (m2r ? rdata : alu);
        dest  = j ? 5'd31 : wr;
        e.we  = (rw || j) && (dest != 5'd0) && !rst;
        e.rd1 = (r1 == 5'd0) ? 32'd0 : ((e.we && r1 == dest) ? e.wb : model[r1]);
        e.rd2 = (r2 == 5'd0) ? 32'd0 : ((e.we && r2 == dest) ? e.wb : model[r2]);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) model_reset();
        else if (e.we) model[dest] = e.wb;
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle; compare mid-cycle.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output({e.tag, ".rd1"}, rd1, e.rd1);
                check_output({e.tag, ".rd2"}, rd2, e.rd2);
                check_output({e.tag, ".wbdata"}, wb_data, e.wb);
                check_output({e.tag, ".we"}, {31'd0, wb_en}, {31'd0, e.we});
            end
        end
    end

    initial begin
        logic [4:0]  wr, r1, r2;
        logic        rw, j, rst;
        // Power-up contents are unknown, so the first reset cycle is driven without a prediction.
        reset = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0; jal = 1'b0; write_reg = 5'd0;
        read_data = 32'd0; alu_result = 32'd0; link_addr = 32'd0; read_reg1 = 5'd0; read_reg2 = 5'd0;
        @(posedge clk);
        model_reset();
        #1;

        apply_stimulus("rst_r0_r28", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd28);
        apply_stimulus("rst_r29_r31", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd29, 5'd31);
        apply_stimulus("alu_bypass", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd8, 5'd8);
        apply_stimulus("alu_stored", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 32'h1111_1111, 32'd0, 5'd8, 5'd9);
        apply_stimulus("mem_write", 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_1234, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd9);
        apply_stimulus("mem_stored", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd8);
        apply_stimulus("jal_write", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'hAAAA_0000, 32'h0040_0010, 5'd31, 5'd5);
        apply_stimulus("jal_stored", 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'd0, 32'd0, 32'd0, 5'd31, 5'd5);
        apply_stimulus("r0_write", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1, 32'd0, 5'd0, 5'd0);
        apply_stimulus("r0_after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        apply_stimulus("no_enable", 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h5555_5555, 32'h6666_6666, 32'd0, 5'd8, 5'd8);
        apply_stimulus("b2b_first", 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0, 32'h0000_00A1, 32'd0, 5'd12, 5'd3);
        apply_stimulus("b2b_second", 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0, 32'h0000_00B2, 32'd0, 5'd12, 5'd12);
        apply_stimulus("sp_write", 1'b0, 1'b1, 1'b0, 1'b0, 5'd29, 32'd0, 32'h1, 32'd0, 5'd29, 5'd12);
        apply_stimulus("rst_with_wr", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'd0, 32'h7, 32'd0, 5'd29, 5'd3);
        apply_stimulus("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd29, 5'd3);
        apply_stimulus("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd12, 5'd8);
        apply_stimulus("first_wr", 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'd0, 32'hCAFE_0004, 32'd0, 5'd4, 5'd28);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 7) == 0);
            wr  = 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 1) == 0) ? (j ? 5'd31 : wr) : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
            apply_stimulus("random", rst, rw, 1'($urandom_range(0, 1)), j, wr, $urandom, $urandom,
                           $urandom, r1, r2);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_register_file.md
WRITEBACK_REGISTER_FILE -- requirements
Module: writeback_register_file

Interface
REQ-001 Parameter SP_INIT, default 32'h7FFF_EFFC, reset value of register 29 ($sp).
REQ-002 Parameter GP_INIT, default 32'h1000_8000, reset value of register 28 ($gp).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-005 RegWrite_input  input  1  write-back enable from the MEM/WB stage register.
REQ-006 MemToReg_input  input  1  1 = write memory data, 0 = write ALU result.
REQ-007 Jal_input  input  1  link write: forces destination 31 and data LinkAddress_input.
REQ-008 WriteRegister_input  input  5  destination register from MEM/WB.
REQ-009 ReadData_input  input  32  memory load data from MEM/WB.
REQ-010 ALUResult_input  input  32  ALU result from MEM/WB.
REQ-011 LinkAddress_input  input  32  return address for jal.
REQ-012 ReadRegister1  input  5  port-1 source address (ID stage).
REQ-013 ReadRegister2  input  5  port-2 source address (ID stage).
REQ-014 ReadData1_output  output  32  port-1 read data.
REQ-015 ReadData2_output  output  32  port-2 read data.
REQ-016 WriteBackData_output  output  32  selected write-back value, for the forwarding unit.
REQ-017 WriteEnable_output  output  1  effective write enable this cycle, for the forwarding unit.

Function
REQ-018 Storage: 32 x 32-bit registers, indices 0..31.
REQ-019 Write data: Jal_input=1 -> LinkAddress_input; else MemToReg_input=1 -> ReadData_input; else ALUResult_input; combinational, driven on WriteBackData_output.
REQ-020 Destination: Jal_input=1 -> 31; else WriteRegister_input.
REQ-021 Effective enable = (RegWrite_input OR Jal_input) AND destination != 0 AND reset = 0; driven on WriteEnable_output.
REQ-022 On rising clk with effective enable = 1, destination register takes write data; all other registers hold.
REQ-023 Register 0 always reads 0; writes to 0 dropped, no storage change, WriteEnable_output = 0.
REQ-024 Reads combinational, zero-cycle latency from address to data.
REQ-025 Write-first bypass: effective enable = 1 and read address == destination (non-zero) -> that port outputs write data in the same cycle, before the edge.
REQ-026 Both ports may read the same address; both return identical values including bypass.
REQ-027 Jal_input=1 with WriteRegister_input != 31 -> register 31 written, WriteRegister_input ignored.
REQ-028 RegWrite_input=0 and Jal_input=0 -> no write, no bypass, regardless of other inputs.
REQ-029 Back-to-back writes to the same register on consecutive cycles: last edge wins; bypass reflects current cycle's data.

Reset
REQ-030 reset=1 at rising clk: registers 28 <- GP_INIT, 29 <- SP_INIT, all others <- 0; any concurrent write request discarded.
REQ-031 While reset=1: WriteEnable_output = 0, bypass disabled, read ports show stored contents.
REQ-032 Reset asserted mid-stream (after writes): same result as REQ-030; no prior content survives except the parameter values.
REQ-033 First write accepted on the first rising clk with reset=0.

Verification
REQ-034 Reset one cycle, read 0/28/29/31 -> 0, 32'h1000_8000, 32'h7FFF_EFFC, 0.
REQ-035 RegWrite=1, MemToReg=0, dest=8, ALU=32'hDEAD_BEEF, ReadRegister1=8 -> ReadData1 = 32'hDEAD_BEEF same cycle (bypass) and after the edge with RegWrite=0.
REQ-036 RegWrite=1, MemToReg=1, dest=9, ReadData=32'h0000_1234, ALU=32'hFFFF_FFFF -> register 9 = 32'h0000_1234.
REQ-037 Jal=1, RegWrite=0, dest=5, Link=32'h0040_0010 -> register 31 = 32'h0040_0010, register 5 unchanged, WriteEnable_output=1.
REQ-038 RegWrite=1, dest=0, ALU=32'h1 -> WriteEnable_output=0, both ports reading 0 return 0 before and after the edge.
REQ-039 Write register 29 = 32'h1, then reset=1 with RegWrite=1, dest=3, ALU=32'h7 in the same cycle -> register 29 = SP_INIT, register 3 = 0.
